// File: rtl/fwd_scoreboard.sv
// Operand-forwarding and hazard unit for the decode/issue stage.
// Each operand is taken from the youngest matching pipeline producer, then
// the multi-cycle completion bus, then the register file. A per-register
// pending scoreboard tracks in-flight multi-cycle ops. A stall is raised on
// load-use, RAW-on-pending, WAW-on-pending or a full long unit. Stall
// cycles are counted for performance reporting.
module fwd_scoreboard #(
   parameter int XLEN     = 64,
   parameter int NREG     = 32,
   parameter int NSRC     = 3,
   parameter int NRD      = 2,
   parameter int MAX_LONG = 4,
   localparam int RW      = $clog2(NREG),
   localparam int CW      = $clog2(MAX_LONG + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NSRC-1:0]      src_valid,
   input  logic [NSRC-1:0]      src_ready,
   input  logic [NSRC*RW-1:0]   src_dst,
   input  logic [NSRC*XLEN-1:0] src_data,
   input  logic [NRD*RW-1:0]    rs,
   input  logic [NRD-1:0]       rs_used,
   input  logic [NRD*XLEN-1:0]  rf_rdata,
   output logic [NRD*XLEN-1:0]  opnd,
   input  logic                 issue,
   input  logic                 issue_long,
   input  logic [RW-1:0]        issue_rd,
   input  logic                 long_done,
   input  logic [RW-1:0]        long_rd,
   input  logic [XLEN-1:0]      long_data,
   input  logic                 flush,
   output logic                 stall,
   output logic [NREG-1:0]      pending,
   output logic [CW-1:0]        long_cnt,
   output logic [31:0]          stall_cycles
);

   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LONG);

   logic [NREG-1:0] pending_q, pending_d;
   logic [CW-1:0]   long_cnt_q, long_cnt_d;
   logic [31:0]     stall_cycles_q, stall_cycles_d;

   logic [RW-1:0]   rs_k;
   logic [XLEN-1:0] sel;
   logic            hit;
   logic            hit_ready;
   logic            long_byp;
   logic            rd_hazard;
   logic            waw;
   logic            full;
   logic            long_acc;
   logic            cnt_dec;

   // Operand select and read-after-write hazard detection for every operand.
   // NOTE: all combinational outputs get a default first so no path leaves
   // them unassigned, which would otherwise infer a latch.
   always_comb begin
      opnd      = '0;
      rd_hazard = 1'b0;
      rs_k      = '0;
      sel       = '0;
      hit       = 1'b0;
      hit_ready = 1'b1;
      long_byp  = 1'b0;
      for (int k = 0; k < NRD; k++) begin
         rs_k      = rs[k*RW +: RW];
         long_byp  = long_done && (long_rd == rs_k);
         sel       = rf_rdata[k*XLEN +: XLEN];
         hit       = 1'b0;
         hit_ready = 1'b1;
         if (long_byp) sel = long_data;
         // Walk oldest to youngest so the youngest match is the last write;
         // a not-ready young load is still selected and blocks older data.
         for (int i = NSRC - 1; i >= 0; i--) begin
            if (src_valid[i] && (src_dst[i*RW +: RW] == rs_k)) begin
               sel       = src_data[i*XLEN +: XLEN];
               hit       = 1'b1;
               hit_ready = src_ready[i];
            end
         end
         if (rs_k == '0) sel = '0;
         opnd[k*XLEN +: XLEN] = sel;
         if (rs_used[k] && (rs_k != '0) &&
             ((hit && !hit_ready) || (pending_q[rs_k] && !long_byp)))
            rd_hazard = 1'b1;
      end
   end

   // Issue-side stall terms and the final stall decision.
   always_comb begin
      waw      = (issue_rd != '0) && pending_q[issue_rd] &&
                 !(long_done && (long_rd == issue_rd));
      full     = issue_long && (long_cnt_q == MAX_CNT) && !long_done;
      stall    = issue && (rd_hazard || waw || full);
      long_acc = issue && issue_long && !stall && !flush;
      cnt_dec  = long_done && (long_cnt_q != '0);
   end

   // Next-state for the scoreboard, in-flight count and stall counter.
   always_comb begin
      pending_d      = pending_q;
      long_cnt_d     = long_cnt_q;
      stall_cycles_d = stall_cycles_q;
      if (flush) begin
         pending_d  = '0;
         long_cnt_d = '0;
      end else begin
         // Clear before set so a same-register issue and completion leaves
         // the new op pending.
         if (long_done) pending_d[long_rd] = 1'b0;
         if (long_acc && (issue_rd != '0)) pending_d[issue_rd] = 1'b1;
         if (long_acc && !cnt_dec)      long_cnt_d = long_cnt_q + 1'b1;
         else if (!long_acc && cnt_dec) long_cnt_d = long_cnt_q - 1'b1;
      end
      if (stall && (stall_cycles_q != 32'hFFFF_FFFF))
         stall_cycles_d = stall_cycles_q + 32'd1;
   end

   // State registers with asynchronous active-low reset.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_q      <= '0;
         long_cnt_q     <= '0;
         stall_cycles_q <= '0;
      end else begin
         pending_q      <= pending_d;
         long_cnt_q     <= long_cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign pending      = pending_q;
   assign long_cnt     = long_cnt_q;
   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: a table of combinational operand
// and stall vectors, then hand-written multi-cycle scoreboard sequences.
module tb_fwd_scoreboard;

   localparam int XLEN = 64;
   localparam int NREG = 32;
   localparam int NSRC = 3;
   localparam int NRD  = 2;
   localparam int ML   = 4;
   localparam int RW   = 5;
   localparam int CW   = 3;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NSRC-1:0]      src_valid, src_ready;
   logic [NSRC*RW-1:0]   src_dst;
   logic [NSRC*XLEN-1:0] src_data;
   logic [NRD*RW-1:0]    rs;
   logic [NRD-1:0]       rs_used;
   logic [NRD*XLEN-1:0]  rf_rdata;
   logic [NRD*XLEN-1:0]  opnd;
   logic                 issue, issue_long, long_done, flush;
   logic [RW-1:0]        issue_rd, long_rd;
   logic [XLEN-1:0]      long_data;
   logic                 stall;
   logic [NREG-1:0]      pending;
   logic [CW-1:0]        long_cnt;
   logic [31:0]          stall_cycles;

   fwd_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NSRC(NSRC), .NRD(NRD),
                    .MAX_LONG(ML)) dut (
      .clk(clk), .reset(reset),
      .src_valid(src_valid), .src_ready(src_ready), .src_dst(src_dst),
      .src_data(src_data), .rs(rs), .rs_used(rs_used), .rf_rdata(rf_rdata),
      .opnd(opnd), .issue(issue), .issue_long(issue_long),
      .issue_rd(issue_rd), .long_done(long_done), .long_rd(long_rd),
      .long_data(long_data), .flush(flush), .stall(stall),
      .pending(pending), .long_cnt(long_cnt), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  sv, sr;
      logic [4:0]  d0, d1, d2;
      logic [63:0] x0, x1, x2;
      logic [4:0]  r0, r1;
      logic [1:0]  used;
      logic        iss, ld;
      logic [4:0]  lrd;
      logic [63:0] ldata;
      logic [63:0] e0, e1;
      logic        est;
   } vec_t;

   vec_t vecs [10];
   int   checks   = 0;
   int   failures = 0;
   int   exp_sc   = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic idle();
      src_valid = '0; src_ready = '0; src_dst = '0; src_data = '0;
      rs = '0; rs_used = '0;
      rf_rdata = {64'h22, 64'h11};
      issue = 0; issue_long = 0; issue_rd = '0;
      long_done = 0; long_rd = '0; long_data = '0; flush = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic long_issue(input logic [4:0] rd);
      issue = 1; issue_long = 1; issue_rd = rd;
   endtask

   initial begin
      // name sv sr d0 d1 d2 x0 x1 x2 r0 r1 used iss ld lrd ldata e0 e1 est
      vecs[0] = '{"fwd_young", 3'b011, 3'b011, 5, 5, 0, 64'hAA, 64'hBB, 0,
                  5, 0, 2'b11, 1, 0, 0, 0, 64'hAA, 64'h0, 0};
      vecs[1] = '{"x0_zero", 3'b001, 3'b001, 0, 0, 0, 64'h77, 0, 0,
                  0, 6, 2'b11, 1, 0, 0, 0, 64'h0, 64'h22, 0};
      vecs[2] = '{"load_use", 3'b011, 3'b010, 7, 7, 0, 64'hC0, 64'h1, 0,
                  3, 7, 2'b11, 1, 0, 0, 0, 64'h11, 64'hC0, 1};
      vecs[3] = '{"load_unused", 3'b011, 3'b010, 7, 7, 0, 64'hC0, 64'h1, 0,
                  3, 7, 2'b01, 1, 0, 0, 0, 64'h11, 64'hC0, 0};
      vecs[4] = '{"load_noissue", 3'b011, 3'b010, 7, 7, 0, 64'hC0, 64'h1, 0,
                  3, 7, 2'b11, 0, 0, 0, 0, 64'h11, 64'hC0, 0};
      vecs[5] = '{"older_fwd", 3'b110, 3'b110, 0, 8, 8, 0, 64'hBB, 64'hCC,
                  8, 8, 2'b11, 1, 0, 0, 0, 64'hBB, 64'hBB, 0};
      vecs[6] = '{"long_bypass", 3'b000, 3'b000, 0, 0, 0, 0, 0, 0,
                  4, 2, 2'b11, 1, 1, 4, 64'h55, 64'h55, 64'h22, 0};
      vecs[7] = '{"prod_over_long", 3'b100, 3'b100, 0, 0, 4, 0, 0, 64'hCC,
                  4, 4, 2'b11, 1, 1, 4, 64'h55, 64'hCC, 64'hCC, 0};
      vecs[8] = '{"mem_notready", 3'b010, 3'b000, 0, 12, 0, 0, 64'hDD, 0,
                  12, 12, 2'b01, 1, 0, 0, 0, 64'hDD, 64'hDD, 1};
      vecs[9] = '{"unrelated_nr", 3'b001, 3'b000, 9, 0, 0, 64'h9, 0, 0,
                  10, 11, 2'b11, 1, 0, 0, 0, 64'h11, 64'h22, 0};

      idle();
      reset = 0;
      #12;
      check("rst_pending", 64'(pending), 0);
      check("rst_cnt", 64'(long_cnt), 0);
      check("rst_sc", 64'(stall_cycles), 0);
      check("rst_stall", 64'(stall), 0);
      reset = 1;
      tick();

      // Combinational operand/stall table, pending scoreboard empty.
      for (int v = 0; v < 10; v++) begin
         idle();
         src_valid = vecs[v].sv; src_ready = vecs[v].sr;
         src_dst   = {vecs[v].d2, vecs[v].d1, vecs[v].d0};
         src_data  = {vecs[v].x2, vecs[v].x1, vecs[v].x0};
         rs        = {vecs[v].r1, vecs[v].r0};
         rs_used   = vecs[v].used;
         issue     = vecs[v].iss;
         long_done = vecs[v].ld; long_rd = vecs[v].lrd;
         long_data = vecs[v].ldata;
         #1;
         check({vecs[v].name, "_opnd0"}, opnd[63:0], vecs[v].e0);
         check({vecs[v].name, "_opnd1"}, opnd[127:64], vecs[v].e1);
         check({vecs[v].name, "_stall"}, 64'(stall), 64'(vecs[v].est));
         if (vecs[v].est) exp_sc++;
         tick();
      end
      idle();
      check("table_sc", 64'(stall_cycles), 64'(exp_sc));

      // Load-use held several cycles: counter climbs once per cycle.
      src_valid = 3'b011; src_ready = 3'b010; src_dst = {5'd0, 5'd7, 5'd7};
      rs = {5'd7, 5'd0}; rs_used = 2'b10; issue = 1;
      for (int c = 0; c < 3; c++) begin
         tick();
         exp_sc++;
         check("hold_sc", 64'(stall_cycles), 64'(exp_sc));
      end
      idle();

      // Long op to x9, RAW stall, then same-cycle completion bypass.
      long_issue(9);
      #1 check("l9_stall", 64'(stall), 0);
      tick(); idle();
      check("l9_pending", 64'(pending), 64'(32'h200));
      check("l9_cnt", 64'(long_cnt), 1);
      issue = 1; rs = {5'd0, 5'd9}; rs_used = 2'b01;
      #1 check("raw_stall", 64'(stall), 1);
      tick(); exp_sc++;
      check("raw_sc", 64'(stall_cycles), 64'(exp_sc));
      long_done = 1; long_rd = 9; long_data = 64'h55;
      #1 check("done_opnd", opnd[63:0], 64'h55);
      check("done_stall", 64'(stall), 0);
      tick(); idle();
      check("done_pending", 64'(pending), 0);
      check("done_cnt", 64'(long_cnt), 0);

      // Fill the long unit, then the full stall and its same-cycle release.
      for (int r = 1; r <= 4; r++) begin
         long_issue(5'(r));
         #1 check("fill_stall", 64'(stall), 0);
         tick();
      end
      idle();
      check("fill_cnt", 64'(long_cnt), 4);
      check("fill_pending", 64'(pending), 64'(32'h1E));
      long_issue(5);
      #1 check("full_stall", 64'(stall), 1);
      long_done = 1; long_rd = 1;
      #1 check("full_release", 64'(stall), 0);
      tick(); idle();
      check("swap_cnt", 64'(long_cnt), 4);
      check("swap_pending", 64'(pending), 64'(32'h3C));

      // WAW on pending x3 until its completion.
      issue = 1; issue_rd = 3;
      #1 check("waw_stall", 64'(stall), 1);
      tick(); exp_sc++;
      check("waw_still", 64'(stall), 1);
      long_done = 1; long_rd = 3;
      #1 check("waw_release", 64'(stall), 0);
      tick(); idle();
      check("waw_pending", 64'(pending), 64'(32'h34));
      check("waw_cnt", 64'(long_cnt), 3);
      check("waw_sc", 64'(stall_cycles), 64'(exp_sc));

      // Flush discards same-cycle issue and done.
      long_issue(7); flush = 1; long_done = 1; long_rd = 2;
      tick(); idle();
      check("flush_pending", 64'(pending), 0);
      check("flush_cnt", 64'(long_cnt), 0);

      // Long issue to x0 counts but sets nothing; then one to x6.
      long_issue(0);
      tick(); idle();
      check("x0_cnt", 64'(long_cnt), 1);
      check("x0_pending", 64'(pending), 0);
      long_issue(6);
      tick(); idle();
      check("x6_cnt", 64'(long_cnt), 2);
      check("x6_pending", 64'(pending), 64'(32'h40));

      // Asynchronous reset mid-cycle, away from any clock edge.
      #2 reset = 0;
      #1;
      check("arst_pending", 64'(pending), 0);
      check("arst_cnt", 64'(long_cnt), 0);
      check("arst_sc", 64'(stall_cycles), 0);
      #1 reset = 1;
      tick();
      check("post_rst_cnt", 64'(long_cnt), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
